// File: rtl/fun_sweep_ctrl.sv
// Exhaustive 4-input sweep controller: drives all 16 vectors into a fun instance,
// samples its output after a settle window and compares it against a golden truth table.
module fun_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expected,
  input  logic        fun_out,
  output logic        a,
  output logic        not_a,
  output logic        b,
  output logic        not_b,
  output logic        c,
  output logic        not_c,
  output logic        d,
  output logic        not_d,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic [4:0]  err_count,
  output logic [3:0]  first_fail,
  output logic        fail_valid
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(15);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       vec;
  logic [3:0]       vec_n;

  // True and complement drives are both flopped so they never glitch apart.
  assign {a, b, c, d}                 = vec;
  assign {not_a, not_b, not_c, not_d} = vec_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      vec         <= '0;
      vec_n       <= '1;
      busy        <= 1'b0;
      done        <= 1'b0;
      truth_table <= '0;
      err_count   <= '0;
      first_fail  <= '0;
      fail_valid  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            busy        <= 1'b1;
            idx         <= '0;
            cnt         <= '0;
            vec         <= '0;
            vec_n       <= '1;
            truth_table <= '0;
            err_count   <= '0;
            fail_valid  <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            // Abort beats a coincident sample; partial results are kept.
            state <= IDLE;
            busy  <= 1'b0;
            vec   <= '0;
            vec_n <= '1;
          end else if (cnt == CNT_LAST) begin
            truth_table[idx] <= fun_out;
            if (fun_out != expected[idx]) begin
              err_count <= err_count + 5'd1;
              if (!fail_valid) begin
                first_fail <= idx;
                fail_valid <= 1'b1;
              end
            end
            cnt <= '0;
            if (idx == IDX_LAST) begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
              vec   <= '0;
              vec_n <= '1;
            end else begin
              idx   <= idx + 4'd1;
              vec   <= idx + 4'd1;
              vec_n <= ~(idx + 4'd1);
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fun_sweep_ctrl.sv
// Directed bench for fun_sweep_ctrl: one instance at SETTLE_CYCLES=2, one at 1,
// each closed around a bench-side model of the fun instance.
module tb_fun_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 1, SETTLE_CYCLES = 2
  logic        rst, start, abort, fun_out, mode;
  logic [15:0] expected;
  logic        a, not_a, b, not_b, c, not_c, d, not_d, busy, done, fail_valid;
  logic [15:0] truth_table;
  logic [4:0]  err_count;
  logic [3:0]  first_fail;

  // Instance 2, SETTLE_CYCLES = 1
  logic        rst2, start2, abort2, fun_out2;
  logic [15:0] expected2;
  logic        a2, not_a2, b2, not_b2, c2, not_c2, d2, not_d2, busy2, done2, fail_valid2;
  logic [15:0] truth_table2;
  logic [4:0]  err_count2;
  logic [3:0]  first_fail2;

  // Model of the fun instance: a&b, or ~a when mode is set.
  assign fun_out  = mode ? ~a : (a & b);
  assign fun_out2 = a2 & b2;

  fun_sweep_ctrl #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .expected(expected),
    .fun_out(fun_out), .a(a), .not_a(not_a), .b(b), .not_b(not_b), .c(c),
    .not_c(not_c), .d(d), .not_d(not_d), .busy(busy), .done(done),
    .truth_table(truth_table), .err_count(err_count), .first_fail(first_fail),
    .fail_valid(fail_valid)
  );

  fun_sweep_ctrl #(.SETTLE_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .abort(abort2), .expected(expected2),
    .fun_out(fun_out2), .a(a2), .not_a(not_a2), .b(b2), .not_b(not_b2), .c(c2),
    .not_c(not_c2), .d(d2), .not_d(not_d2), .busy(busy2), .done(done2),
    .truth_table(truth_table2), .err_count(err_count2), .first_fail(first_fail2),
    .fail_valid(fail_valid2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset1(input string tag);
    check({tag, "_abcd"}, 32'({a, b, c, d}), 32'h0);
    check({tag, "_not"}, 32'({not_a, not_b, not_c, not_d}), 32'hF);
    check({tag, "_busy_done"}, 32'({busy, done}), 32'h0);
    check({tag, "_tt"}, 32'(truth_table), 32'h0);
    check({tag, "_err"}, 32'(err_count), 32'h0);
    check({tag, "_ff_fv"}, 32'({first_fail, fail_valid}), 32'h0);
  endtask

  task automatic check_reset2(input string tag);
    check({tag, "_abcd"}, 32'({a2, b2, c2, d2}), 32'h0);
    check({tag, "_not"}, 32'({not_a2, not_b2, not_c2, not_d2}), 32'hF);
    check({tag, "_busy_done"}, 32'({busy2, done2}), 32'h0);
    check({tag, "_tt"}, 32'(truth_table2), 32'h0);
    check({tag, "_err"}, 32'(err_count2), 32'h0);
    check({tag, "_ff_fv"}, 32'({first_fail2, fail_valid2}), 32'h0);
  endtask

  // Full sweep on instance 1; extra start pulses land on edges E0+p1 and E0+p2.
  task automatic do_sweep(input logic [15:0] exp_v, input int p1, input int p2);
    int done_cnt = 0;
    int done_at  = 0;
    int busy_gap = 0;
    int overlap  = 0;
    expected = exp_v;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("sweep_busy_e0", 32'(busy), 32'h1);
    for (int n = 1; n <= 40; n++) begin
      if (n == p1 || n == p2) start = 1'b1;
      tick();
      start = 1'b0;
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = n;
      end
      if (n < 32 && !busy && busy_gap == 0) busy_gap = n;
      if (busy && done) overlap++;
      if (n == 3)  check("sweep_vec1", 32'({a, b, c, d}), 32'h1);
      if (n == 11) check("sweep_vec5", 32'({a, b, c, d}), 32'h5);
      if (n == 11) check("sweep_not5", 32'({not_a, not_b, not_c, not_d}), 32'hA);
    end
    check("sweep_done_cnt", 32'(done_cnt), 32'd1);
    check("sweep_done_at", 32'(done_at), 32'd32);
    check("sweep_busy_gap", 32'(busy_gap), 32'd0);
    check("sweep_overlap", 32'(overlap), 32'd0);
    check("sweep_idle_end", 32'({busy, a, b, c, d}), 32'h0);
  endtask

  initial begin
    int done_cnt;
    int done_at;
    mode = 1'b0;
    rst = 1'b1; start = 1'b1; abort = 1'b0; expected = 16'h0;
    rst2 = 1'b1; start2 = 1'b0; abort2 = 1'b0; expected2 = 16'h0;
    tick();
    check("rst_hold_not", 32'({not_a, not_b, not_c, not_d}), 32'hF);
    tick();
    rst = 1'b0; start = 1'b0; rst2 = 1'b0;
    check_reset1("reset");
    check_reset2("reset2");
    repeat (3) tick();
    check("no_auto_start", 32'({busy, done}), 32'h0);

    // Pass sweep
    do_sweep(16'hF000, -1, -1);
    check("pass_tt", 32'(truth_table), 32'hF000);
    check("pass_err", 32'(err_count), 32'd0);
    check("pass_fv", 32'(fail_valid), 32'h0);

    // Fail sweep with ignored start pulses during busy
    do_sweep(16'hF081, 5, 31);
    check("fail_tt", 32'(truth_table), 32'hF000);
    check("fail_err", 32'(err_count), 32'd2);
    check("fail_ff", 32'(first_fail), 32'd0);
    check("fail_fv", 32'(fail_valid), 32'h1);

    // Abort while vector 6 is held (edge E0+13); fun = ~a
    mode = 1'b1;
    expected = 16'h0007;
    start = 1'b1;
    tick();
    start = 1'b0;
    done_cnt = 0;
    for (int n = 1; n <= 24; n++) begin
      if (n == 13) begin
        check("abort_vec6", 32'({a, b, c, d}), 32'h6);
        abort = 1'b1;
      end
      tick();
      abort = 1'b0;
      if (done) done_cnt++;
      if (n == 13) begin
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_abcd", 32'({a, b, c, d}), 32'h0);
        check("abort_not", 32'({not_a, not_b, not_c, not_d}), 32'hF);
      end
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_tt", 32'(truth_table), 32'h003F);
    check("abort_err", 32'(err_count), 32'd3);
    check("abort_ff", 32'(first_fail), 32'd3);
    check("abort_fv", 32'(fail_valid), 32'h1);
    mode = 1'b0;

    // Instance 2: reset during vector 9
    expected2 = 16'h0010;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      if (n == 10) begin
        check("s1_vec9", 32'({a2, b2, c2, d2}), 32'h9);
        check("s1_partial", 32'({err_count2, first_fail2, fail_valid2}), 32'({5'd1, 4'd4, 1'b1}));
        rst2 = 1'b1;
        start2 = 1'b1;
      end
      tick();
      rst2 = 1'b0;
      start2 = 1'b0;
    end
    check_reset2("midrst");

    // Instance 2: fresh sweep, one sample per cycle
    expected2 = 16'hF000;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    done_cnt = 0;
    done_at = 0;
    for (int n = 1; n <= 24; n++) begin
      tick();
      if (done2) begin
        done_cnt++;
        if (done_at == 0) done_at = n;
      end
    end
    check("s1_done_cnt", 32'(done_cnt), 32'd1);
    check("s1_done_at", 32'(done_at), 32'd16);
    check("s1_tt", 32'(truth_table2), 32'hF000);
    check("s1_err_fv", 32'({err_count2, fail_valid2}), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fun_sweep_ctrl.md
FUN_SWEEP_CTRL -- requirements
Module: fun_sweep_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: number of clk cycles each input vector is held before the fun output is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request one full 16-vector sweep; sampled only in IDLE.
REQ-005 abort  input  1  terminate the current sweep; ignored in IDLE.
REQ-006 expected  input  16  golden truth table; bit k is the required output for vector k.
REQ-007 fun_out  input  1  output of the fun instance under control.
REQ-008 a, not_a, b, not_b, c, not_c, d, not_d  output  1 each  drive to the fun instance.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse when a sweep completes.
REQ-011 truth_table  output  16  captured fun_out values; bit k holds the result for vector k.
REQ-012 err_count  output  5  number of vectors where the captured value differs from expected (range 0..16).
REQ-013 first_fail  output  4  lowest failing vector index.
REQ-014 fail_valid  output  1  high when first_fail is meaningful.

Function
REQ-015 The vector index idx is 4 bits and maps {a,b,c,d} = idx[3:0], so a is the MSB; sweep order is 0 to 15 ascending.
REQ-016 not_x shall equal ~x in every cycle, including during reset.
REQ-017 The block shall be a state machine with three states:
- IDLE: waits for start.
- RUN: drives, settles and samples vectors.
- DONE: one cycle, then returns to IDLE.
REQ-018 IDLE to RUN on an edge with start=1:
- idx set to 0 and the settle counter set to 0;
- truth_table, err_count and fail_valid cleared at that edge.
REQ-019 In RUN the current vector is held on the a..d outputs for exactly SETTLE_CYCLES cycles.
REQ-020 fun_out is sampled at the edge that ends the hold window of a vector; that same edge writes truth_table[idx].
REQ-021 At that sampling edge, if fun_out != expected[idx]:
- err_count increments;
- if fail_valid=0, first_fail is set to idx and fail_valid to 1.
REQ-022 At a sampling edge with idx<15, idx increments and the settle counter restarts at 0.
REQ-023 At the sampling edge with idx=15 the state moves to DONE; idx shall not wrap to 0 while in RUN.
REQ-024 Sweep latency from the start-accepting edge E0:
- final sample at edge E0+16*SETTLE_CYCLES;
- done is high in the cycle immediately after that edge.
REQ-025 busy = 1 exactly while in RUN; done = 1 exactly while in DONE; busy and done are never high together.
REQ-026 start asserted in RUN or DONE is ignored, not queued.
REQ-027 abort=1 in RUN returns the block to IDLE at that edge:
- done is not pulsed;
- truth_table, err_count, first_fail and fail_valid keep their partial values;
- a..d return to 0.
REQ-028 If abort and a sampling edge coincide, abort wins and the sample is discarded.
REQ-029 In IDLE and DONE the a..d outputs are 0; the result outputs hold until the next accepted start.
REQ-030 expected is read combinationally at each sampling edge; it may change between sweeps.

Reset
REQ-031 rst=1 at an edge forces, regardless of state including mid-sweep:
- state IDLE, idx=0, settle counter=0;
- a,b,c,d=0 and not_a..not_d=1;
- busy=0, done=0;
- truth_table=0, err_count=0, first_fail=0, fail_valid=0.
REQ-032 rst has priority over start and abort.

Verification
REQ-033 Reset: assert rst 2 cycles with start=1 -> after release all outputs at REQ-031 values; no sweep begins until start is reasserted.
REQ-034 Pass sweep: fun_out=a&b, expected=16'hF000, SETTLE_CYCLES=2 -> done pulses 1 cycle after edge E0+32; truth_table=16'hF000, err_count=0, fail_valid=0.
REQ-035 Fail sweep: fun_out=a&b, expected=16'hF081 -> truth_table=16'hF000, err_count=2, first_fail=0, fail_valid=1.
REQ-036 Start during busy: pulse start at edges E0+5 and E0+31 -> exactly one done pulse, at the REQ-024 time; busy stays continuously high until then.
REQ-037 Abort: assert abort during vector 6 -> next cycle IDLE, no done; truth_table bits 0..5 valid and bits 6..15 equal 0.
REQ-038 Reset mid-sweep and SETTLE_CYCLES=1: rst during vector 9 -> REQ-031 values; a fresh start then completes 16 samples with done 1 cycle after edge E0+16.
